missile_pool: RTL and testbench

- Multi-slot missile manager and renderer in the video pipeline. Successor to the single-missile draw stage.
- Holds up to N_MISSILES independent missiles. Accepts fire requests from ship logic and moves every missile once per frame in a selectable direction (up for the player, down for enemies).
- Retires a missile when it leaves the screen or when collision logic reports a hit.
- Overlays all active missiles on the incoming RGB stream with one cycle of latency, passing timing signals through aligned.

---
 rtl/missile_pool.sv | 189 ++++++++++++++++++
 tb/tb_missile_pool.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/missile_pool.sv
// Multi-slot missile manager: spawns shots from the ship, moves them once per frame,
// retires them off-screen or on hit, and overlays them on the RGB stream (1-cycle latency).
module missile_pool #(
   parameter int N_MISSILES       = 4,
   parameter int DIR_DOWN         = 0,
   parameter int WIDTH_RECT       = 5,
   parameter int HEIGHT_RECT      = 20,
   parameter int X_MISSILE_OFFSET = 21,
   parameter int SHIP_H           = 64,
   parameter int SPEED            = 4,
   parameter int COOLDOWN         = 8,
   parameter int SCREEN_H         = 600,
   parameter logic [11:0] COLOR   = 12'hdd3
) (
   input  logic                       pclk,
   input  logic                       rst_n,
   input  logic [10:0]                xpos,
   input  logic [10:0]                ypos,
   input  logic                       fire,
   output logic                       fire_ack,
   input  logic [N_MISSILES-1:0]      hit,
   output logic [N_MISSILES-1:0]      active,
   output logic [11*N_MISSILES-1:0]   missile_x,
   output logic [11*N_MISSILES-1:0]   missile_y,
   input  logic [10:0]                vcount_in,
   input  logic [10:0]                hcount_in,
   input  logic                       vsync_in,
   input  logic                       hsync_in,
   input  logic                       vblnk_in,
   input  logic                       hblnk_in,
   input  logic [11:0]                rgb_in,
   output logic [10:0]                vcount_out,
   output logic [10:0]                hcount_out,
   output logic                       vsync_out,
   output logic                       hsync_out,
   output logic                       vblnk_out,
   output logic                       hblnk_out,
   output logic [11:0]                rgb_out
);

   logic                  vblnk_prev_reg;
   logic                  frame_tick;
   logic [15:0]           cooldown_reg;
   logic [N_MISSILES-1:0] active_reg;
   logic [N_MISSILES-1:0] spawn_sel;
   logic [N_MISSILES-1:0] in_box;
   logic                  slot_found;
   logic                  fire_accept;
   logic [10:0]           spawn_x;
   logic [10:0]           spawn_y;
   logic [11:0]           h_ext;
   logic [11:0]           v_ext;

   assign frame_tick = vblnk_in & ~vblnk_prev_reg;
   assign active     = active_reg;
   assign h_ext      = {1'b0, hcount_in};
   assign v_ext      = {1'b0, vcount_in};

   // Only slots already free at the start of the cycle are eligible, so a slot
   // cleared by hit or retired this cycle is never reused on the same edge.
   always_comb begin
      spawn_sel  = '0;
      slot_found = 1'b0;
      for (int i = 0; i < N_MISSILES; i++) begin
         if (!active_reg[i] && !slot_found) begin
            spawn_sel[i] = 1'b1;
            slot_found   = 1'b1;
         end
      end
   end

   assign fire_accept = fire && (cooldown_reg == 16'd0) && slot_found;

   always_comb begin
      spawn_x = xpos + 11'(X_MISSILE_OFFSET);
      spawn_y = 11'd0;
      if (DIR_DOWN != 0) begin
         spawn_y = ypos + 11'(SHIP_H);
      end else if ({1'b0, ypos} >= 12'(HEIGHT_RECT)) begin
         spawn_y = ypos - 11'(HEIGHT_RECT);
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vblnk_prev_reg <= 1'b0;
         cooldown_reg   <= 16'd0;
         fire_ack       <= 1'b0;
      end else begin
         vblnk_prev_reg <= vblnk_in;
         fire_ack       <= fire_accept;
         if (fire_accept) begin
            cooldown_reg <= 16'(COOLDOWN);
         end else if (frame_tick && (cooldown_reg != 16'd0)) begin
            cooldown_reg <= cooldown_reg - 16'd1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_MISSILES; gi++) begin : g_slot
         logic [10:0] x_reg;
         logic [10:0] y_reg;
         logic        active_slot_reg;
         logic [11:0] y_ext;
         logic [11:0] y_moved;
         logic        retire;

         assign y_ext = {1'b0, y_reg};

         always_comb begin
            retire  = 1'b0;
            y_moved = y_ext;
            if (DIR_DOWN != 0) begin
               if (y_ext + 12'(SPEED) + 12'(HEIGHT_RECT) > 12'(SCREEN_H)) begin
                  retire = 1'b1;
               end else begin
                  y_moved = y_ext + 12'(SPEED);
               end
            end else begin
               if (y_ext < 12'(SPEED)) begin
                  retire = 1'b1;
               end else begin
                  y_moved = y_ext - 12'(SPEED);
               end
            end
         end

         // hit beats motion beats spawn; a freshly spawned missile skips this tick
         always_ff @(posedge pclk or negedge rst_n) begin
            if (!rst_n) begin
               x_reg           <= 11'd0;
               y_reg           <= 11'd0;
               active_slot_reg <= 1'b0;
            end else if (active_slot_reg && hit[gi]) begin
               active_slot_reg <= 1'b0;
            end else if (active_slot_reg && frame_tick) begin
               if (retire) begin
                  active_slot_reg <= 1'b0;
               end else begin
                  y_reg <= y_moved[10:0];
               end
            end else if (!active_slot_reg && fire_accept && spawn_sel[gi]) begin
               x_reg           <= spawn_x;
               y_reg           <= spawn_y;
               active_slot_reg <= 1'b1;
            end
         end

         assign active_reg[gi]          = active_slot_reg;
         assign missile_x[11*gi +: 11]  = x_reg;
         assign missile_y[11*gi +: 11]  = y_reg;

         assign in_box[gi] = active_slot_reg
                          && (h_ext >= {1'b0, x_reg})
                          && (h_ext <  {1'b0, x_reg} + 12'(WIDTH_RECT))
                          && (v_ext >= {1'b0, y_reg})
                          && (v_ext <  {1'b0, y_reg} + 12'(HEIGHT_RECT));
      end
   endgenerate

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vcount_out <= 11'd0;
         hcount_out <= 11'd0;
         vsync_out  <= 1'b0;
         hsync_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         rgb_out    <= 12'd0;
      end else begin
         vcount_out <= vcount_in;
         hcount_out <= hcount_in;
         vsync_out  <= vsync_in;
         hsync_out  <= hsync_in;
         vblnk_out  <= vblnk_in;
         hblnk_out  <= hblnk_in;
         if (vblnk_in || hblnk_in) begin
            rgb_out <= 12'd0;
         end else if (|in_box) begin
            rgb_out <= COLOR;
         end else begin
            rgb_out <= rgb_in;
         end
      end
   end

endmodule

// File: tb/tb_missile_pool.sv
// Directed bench for missile_pool: an upward pool with cooldown (dut_a) and a
// downward pool without cooldown (dut_b) share timing stimulus.
module tb_missile_pool;

   logic        pclk;
   logic        rst_n;
   logic [10:0] xpos, ypos;
   logic        fire_a, fire_b;
   logic        fire_ack_a, fire_ack_b;
   logic [3:0]  hit_a, hit_b;
   logic [3:0]  active_a, active_b;
   logic [43:0] missile_x_a, missile_y_a, missile_x_b, missile_y_b;
   logic [10:0] vcount_in, hcount_in;
   logic        vsync_in, hsync_in, vblnk_in, hblnk_in;
   logic [11:0] rgb_in;
   logic [10:0] vcount_out_a, hcount_out_a, vcount_out_b, hcount_out_b;
   logic        vsync_out_a, hsync_out_a, vblnk_out_a, hblnk_out_a;
   logic        vsync_out_b, hsync_out_b, vblnk_out_b, hblnk_out_b;
   logic [11:0] rgb_out_a, rgb_out_b;

   int n_checks = 0;
   int n_errors = 0;
   int acks;

   missile_pool dut_a (
      .pclk(pclk), .rst_n(rst_n), .xpos(xpos), .ypos(ypos),
      .fire(fire_a), .fire_ack(fire_ack_a), .hit(hit_a), .active(active_a),
      .missile_x(missile_x_a), .missile_y(missile_y_a),
      .vcount_in(vcount_in), .hcount_in(hcount_in),
      .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
      .rgb_in(rgb_in),
      .vcount_out(vcount_out_a), .hcount_out(hcount_out_a),
      .vsync_out(vsync_out_a), .hsync_out(hsync_out_a),
      .vblnk_out(vblnk_out_a), .hblnk_out(hblnk_out_a), .rgb_out(rgb_out_a)
   );

   missile_pool #(.DIR_DOWN(1), .COOLDOWN(0)) dut_b (
      .pclk(pclk), .rst_n(rst_n), .xpos(xpos), .ypos(ypos),
      .fire(fire_b), .fire_ack(fire_ack_b), .hit(hit_b), .active(active_b),
      .missile_x(missile_x_b), .missile_y(missile_y_b),
      .vcount_in(vcount_in), .hcount_in(hcount_in),
      .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
      .rgb_in(rgb_in),
      .vcount_out(vcount_out_b), .hcount_out(hcount_out_b),
      .vsync_out(vsync_out_b), .hsync_out(hsync_out_b),
      .vblnk_out(vblnk_out_b), .hblnk_out(hblnk_out_b), .rgb_out(rgb_out_b)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic frame();
      vblnk_in = 1'b1;
      step();
      vblnk_in = 1'b0;
      step();
   endtask

   task automatic pix(input logic [10:0] h, input logic [10:0] v);
      hcount_in = h;
      vcount_in = v;
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      xpos = 11'd0; ypos = 11'd0;
      fire_a = 1'b0; fire_b = 1'b0; hit_a = 4'd0; hit_b = 4'd0;
      vcount_in = 11'd0; hcount_in = 11'd0;
      vsync_in = 1'b0; hsync_in = 1'b0; vblnk_in = 1'b0; hblnk_in = 1'b0;
      rgb_in = 12'h123;
      repeat (3) step();
      check("rst_rgb", 32'(rgb_out_a), 32'h0);
      check("rst_active", 32'(active_a), 32'h0);
      rst_n = 1'b1;
      step();
      check("post_rst_active", 32'(active_a), 32'h0);
      check("post_rst_ack", 32'(fire_ack_a), 32'h0);

      // single shot, upward
      xpos = 11'd100; ypos = 11'd500; fire_a = 1'b1;
      step();
      fire_a = 1'b0;
      check("shot_ack", 32'(fire_ack_a), 32'h1);
      check("shot_active", 32'(active_a), 32'h1);
      check("shot_x", 32'(missile_x_a[10:0]), 32'd121);
      check("shot_y", 32'(missile_y_a[10:0]), 32'd480);
      step();
      check("shot_ack_drop", 32'(fire_ack_a), 32'h0);
      repeat (3) frame();
      check("move3_y", 32'(missile_y_a[10:0]), 32'd468);

      pix(11'd121, 11'd468);
      check("pix_121_468", 32'(rgb_out_a), 32'hdd3);
      check("hcount_dly", 32'(hcount_out_a), 32'd121);
      check("vcount_dly", 32'(vcount_out_a), 32'd468);
      pix(11'd125, 11'd487);
      check("pix_125_487", 32'(rgb_out_a), 32'hdd3);
      pix(11'd126, 11'd468);
      check("pix_126_468", 32'(rgb_out_a), 32'h123);
      pix(11'd121, 11'd488);
      check("pix_121_488", 32'(rgb_out_a), 32'h123);
      hblnk_in = 1'b1;
      pix(11'd121, 11'd470);
      check("pix_hblnk", 32'(rgb_out_a), 32'h0);
      check("hblnk_dly", 32'(hblnk_out_a), 32'h1);
      hblnk_in = 1'b0;

      // cooldown: 3 ticks consumed, 5 remain before the next shot
      fire_a = 1'b1;
      step();
      check("cd_block_ack", 32'(fire_ack_a), 32'h0);
      repeat (4) frame();
      check("cd_block_active", 32'(active_a), 32'h1);
      vblnk_in = 1'b1;
      step();
      check("cd_tick8_active", 32'(active_a), 32'h1);
      vblnk_in = 1'b0;
      step();
      check("cd_ack", 32'(fire_ack_a), 32'h1);
      check("cd_active", 32'(active_a), 32'h3);
      check("cd_y0", 32'(missile_y_a[10:0]), 32'd448);
      check("cd_y1", 32'(missile_y_a[21:11]), 32'd480);
      ypos = 11'd24;
      step();
      check("cd_reload_ack", 32'(fire_ack_a), 32'h0);
      repeat (7) frame();
      vblnk_in = 1'b1;
      step();
      vblnk_in = 1'b0;
      step();
      fire_a = 1'b0;
      check("spawn2_ack", 32'(fire_ack_a), 32'h1);
      check("spawn2_active", 32'(active_a), 32'h7);
      check("spawn2_y", 32'(missile_y_a[32:22]), 32'd4);
      check("spawn2_y0", 32'(missile_y_a[10:0]), 32'd416);

      // top edge: y=4 -> 0 stays, y=0 retires
      frame();
      check("top_y0_active", 32'(active_a), 32'h7);
      check("top_y0", 32'(missile_y_a[32:22]), 32'd0);
      frame();
      check("top_retire", 32'(active_a), 32'h3);
      pix(11'd121, 11'd0);
      check("retired_not_drawn", 32'(rgb_out_a), 32'h123);

      // hit handling
      hit_a = 4'b0010;
      step();
      hit_a = 4'b0000;
      check("hit_clear", 32'(active_a), 32'h1);
      hit_a = 4'b1000;
      step();
      hit_a = 4'b0000;
      check("hit_inactive", 32'(active_a), 32'h1);

      // downward pool fills without cooldown
      ypos = 11'd50; fire_b = 1'b1; acks = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         acks += int'(fire_ack_b);
      end
      fire_b = 1'b0;
      check("full_acks", 32'(acks), 32'd4);
      check("full_active", 32'(active_b), 32'hf);
      check("full_y3", 32'(missile_y_b[43:33]), 32'd114);
      check("full_x3", 32'(missile_x_b[43:33]), 32'd121);

      // hit + tick + fire on one edge, pool full: rejected
      vblnk_in = 1'b1; hit_b = 4'b0001; fire_b = 1'b1;
      step();
      vblnk_in = 1'b0; hit_b = 4'b0000; fire_b = 1'b0;
      check("simul_active", 32'(active_b), 32'he);
      check("simul_noack", 32'(fire_ack_b), 32'h0);
      check("simul_y1", 32'(missile_y_b[21:11]), 32'd118);
      step();
      // slot 0 free beforehand: spawn lands there unmoved, slot 1 killed
      vblnk_in = 1'b1; hit_b = 4'b0010; fire_b = 1'b1;
      step();
      vblnk_in = 1'b0; hit_b = 4'b0000; fire_b = 1'b0;
      check("simul2_active", 32'(active_b), 32'hd);
      check("simul2_ack", 32'(fire_ack_b), 32'h1);
      check("simul2_y0", 32'(missile_y_b[10:0]), 32'd114);
      check("simul2_y2", 32'(missile_y_b[32:22]), 32'd122);
      step();

      // bottom edge
      hit_b = 4'b1111;
      step();
      hit_b = 4'b0000;
      check("clear_all", 32'(active_b), 32'h0);
      ypos = 11'd512; fire_b = 1'b1;
      step();
      ypos = 11'd513;
      step();
      fire_b = 1'b0;
      check("bot_y0", 32'(missile_y_b[10:0]), 32'd576);
      check("bot_y1", 32'(missile_y_b[21:11]), 32'd577);
      frame();
      check("bot_retire577", 32'(active_b), 32'h1);
      check("bot_y0_moved", 32'(missile_y_b[10:0]), 32'd580);
      frame();
      check("bot_retire580", 32'(active_b), 32'h0);

      // asynchronous reset with two missiles in flight
      ypos = 11'd50; fire_b = 1'b1;
      step();
      step();
      fire_b = 1'b0;
      check("pre_rst_active", 32'(active_b), 32'h3);
      hcount_in = 11'd7; vcount_in = 11'd9; hsync_in = 1'b1;
      step();
      check("pre_rst_hcount", 32'(hcount_out_b), 32'd7);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_active_b", 32'(active_b), 32'h0);
      check("arst_y_b", 32'(missile_y_b[10:0]), 32'h0);
      check("arst_hcount", 32'(hcount_out_b), 32'h0);
      check("arst_hsync", 32'(hsync_out_b), 32'h0);
      check("arst_active_a", 32'(active_a), 32'h0);
      check("arst_rgb_a", 32'(rgb_out_a), 32'h0);
      step();
      rst_n = 1'b1; fire_a = 1'b1; fire_b = 1'b1;
      step();
      fire_a = 1'b0; fire_b = 1'b0;
      check("rel_ack_b", 32'(fire_ack_b), 32'h1);
      check("rel_active_b", 32'(active_b), 32'h1);
      check("rel_ack_a", 32'(fire_ack_a), 32'h1);
      check("rel_y_a", 32'(missile_y_a[10:0]), 32'd30);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
